// File: rtl/qld_w4q2_div.sv
// Approximate (Mitchell) signed 8-bit divider: log-encode, subtract, antilog-decode.
// Three register stages behind a valid/ready stream; quotient is Q8.8 magnitude, ones-complement sign.
module qld_w4q2_div #(
   parameter int unsigned FRAC_W = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_x,
   input  logic [7:0]  in_y,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_q,
   output logic        out_dz
);

   localparam int unsigned LOG_W = 3 + FRAC_W;
   localparam int unsigned DIF_W = 4 + FRAC_W;
   localparam int unsigned M_W   = FRAC_W + 1;

   // log = {leading-one index, FRAC_W bits below it}; normalising left zero-pads short operands
   function automatic logic [LOG_W-1:0] log_enc(input logic [7:0] a);
      logic [2:0] k;
      logic [7:0] n;
      k = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (a[i]) k = 3'(i);
      end
      n = a << (3'd7 - k);
      return {k, n[6 -: FRAC_W]};
   endfunction

   logic en;

   // stage 1: encode
   logic [7:0]       abs_x_c, abs_y_c;
   logic             v1_q, sign1_q, xz1_q, yz1_q;
   logic             sign1_d, xz1_d, yz1_d;
   logic [LOG_W-1:0] logx1_q, logy1_q, logx1_d, logy1_d;

   // stage 2: subtract
   logic [DIF_W-1:0] d_c;
   logic             v2_q, sign2_q, xz2_q, yz2_q;
   logic [3:0]       kq2_q, kq2_d;
   logic [FRAC_W-1:0] fq2_q, fq2_d;

   // stage 3: decode
   logic [M_W-1:0]   m_c;
   logic [15:0]      mag_c, q3_d;
   logic             dz3_d;
   int               s_c;

   assign en       = ~out_valid | out_ready;
   assign in_ready = en;

   always_comb begin
      abs_x_c = in_x ^ {8{in_x[7]}};
      abs_y_c = in_y ^ {8{in_y[7]}};
      sign1_d = in_x[7] ^ in_y[7];
      xz1_d   = (abs_x_c == 8'd0);
      yz1_d   = (abs_y_c == 8'd0);
      logx1_d = log_enc(abs_x_c);
      logy1_d = log_enc(abs_y_c);
   end

   // borrow out of the fraction field lands naturally in the signed integer part
   always_comb begin
      d_c   = {1'b0, logx1_q} - {1'b0, logy1_q};
      kq2_d = d_c[DIF_W-1:FRAC_W];
      fq2_d = d_c[FRAC_W-1:0];
   end

   always_comb begin
      m_c   = {1'b1, fq2_q};
      s_c   = int'($signed(kq2_q)) + 8 - int'(FRAC_W);
      mag_c = 16'd0;
      q3_d  = 16'd0;
      dz3_d = 1'b0;
      if (s_c >= 0) begin
         mag_c = 16'(m_c) << s_c;
      end else begin
         mag_c = 16'(m_c) >> (-s_c);
      end
      if (yz2_q) begin
         q3_d  = 16'h7FFF ^ {16{sign2_q}};
         dz3_d = 1'b1;
      end else if (xz2_q) begin
         q3_d  = 16'h0000;
      end else begin
         q3_d  = mag_c ^ {16{sign2_q}};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_q      <= 1'b0;
         sign1_q   <= 1'b0;
         xz1_q     <= 1'b0;
         yz1_q     <= 1'b0;
         logx1_q   <= '0;
         logy1_q   <= '0;
         v2_q      <= 1'b0;
         sign2_q   <= 1'b0;
         xz2_q     <= 1'b0;
         yz2_q     <= 1'b0;
         kq2_q     <= 4'd0;
         fq2_q     <= '0;
         out_valid <= 1'b0;
         out_q     <= 16'd0;
         out_dz    <= 1'b0;
      end else if (en) begin
         v1_q      <= in_valid;
         sign1_q   <= sign1_d;
         xz1_q     <= xz1_d;
         yz1_q     <= yz1_d;
         logx1_q   <= logx1_d;
         logy1_q   <= logy1_d;
         v2_q      <= v1_q;
         sign2_q   <= sign1_q;
         xz2_q     <= xz1_q;
         yz2_q     <= yz1_q;
         kq2_q     <= kq2_d;
         fq2_q     <= fq2_d;
         out_valid <= v2_q;
         out_q     <= q3_d;
         out_dz    <= dz3_d;
      end
   end

endmodule
